// File: rtl/core_pkg.sv
// Shared core types: register index, writeback FIFO sizing and the base opcode map.
package core_pkg;

  typedef logic [4:0] RegIdx;

  localparam RegIdx       REG_ZERO      = 5'd0;
  localparam int unsigned WB_FIFO_DEPTH = 4;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } Opcode;

endpackage

// File: rtl/dest_fifo.sv
// In-order FIFO of destination register indices claimed at issue, popped on writeback.
module dest_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clk_en,
  input  logic  i_push,
  input  logic  i_pop,
  input  RegIdx i_din,
  output RegIdx o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  RegIdx          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q;
  logic           do_push, do_pop;

  assign o_full  = (count_q == (PW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_dout  = mem_q[rd_ptr_q];

  assign do_push = i_clk_en & i_push & ~o_full;
  assign do_pop  = i_clk_en & i_pop & ~o_empty;

  // Storage needs no reset: entries are only read after being pushed.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_rst) begin
      mem_q[wr_ptr_q] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage merged with the integer register file: commits execute results in issue
// order, tracks pending writes in a busy scoreboard and supplies registered operands.
module regfile_writeback
  import core_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned DEPTH  = WB_FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_stall,
  input  logic [RIDX_W-1:0] i_rs1_idx,
  input  logic [RIDX_W-1:0] i_rs2_idx,
  input  logic [RIDX_W-1:0] i_rd_idx,
  input  logic              i_issue,
  output logic [DW-1:0]     o_rs1,
  output logic [DW-1:0]     o_rs2,
  output logic              o_hazard,
  input  logic              i_rd_write,
  input  logic [DW-1:0]     i_rd,
  output logic              o_empty,
  output logic              o_underflow
);

  logic [DW-1:0]    regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [DW-1:0]    rs1_d, rs2_d;
  logic             fifo_full, fifo_empty;
  RegIdx            head_idx;
  logic             issue_ok, wb_commit, wb_reg;

  // Registered busy only: a bit clearing this cycle still stalls this cycle.
  assign o_hazard = busy_q[i_rs1_idx] | busy_q[i_rs2_idx] |
                    (i_issue & busy_q[i_rd_idx]) | fifo_full;

  assign issue_ok  = i_clk_en & i_issue & ~o_hazard;
  assign wb_commit = i_clk_en & i_rd_write & ~fifo_empty;
  assign wb_reg    = wb_commit & (head_idx != REG_ZERO);
  assign o_empty   = fifo_empty;

  dest_fifo #(
    .DEPTH (DEPTH)
  ) u_dest_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clk_en (i_clk_en),
    .i_push   (i_issue & ~o_hazard),
    .i_pop    (i_rd_write),
    .i_din    (i_rd_idx),
    .o_dout   (head_idx),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  always_comb begin
    busy_d = busy_q;
    if (wb_reg) busy_d[head_idx] = 1'b0;
    if (issue_ok && (i_rd_idx != REG_ZERO)) busy_d[i_rd_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Write-first bypass so an operand read in the commit cycle sees the new value.
  always_comb begin
    if (i_rs1_idx == REG_ZERO) begin
      rs1_d = '0;
    end else if (wb_reg && (head_idx == i_rs1_idx)) begin
      rs1_d = i_rd;
    end else begin
      rs1_d = regs_q[i_rs1_idx];
    end
  end

  always_comb begin
    if (i_rs2_idx == REG_ZERO) begin
      rs2_d = '0;
    end else if (wb_reg && (head_idx == i_rs2_idx)) begin
      rs2_d = i_rd;
    end else begin
      rs2_d = regs_q[i_rs2_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_underflow <= 1'b0;
    end else if (i_clk_en) begin
      busy_q <= busy_d;
      if (wb_reg) regs_q[head_idx] <= i_rd;
      if (!i_stall) begin
        o_rs1 <= rs1_d;
        o_rs2 <= rs2_d;
      end
      if (i_rd_write && fifo_empty) o_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage downstream of execute, merged with the integer register file.
- Commits execute results (rd write strobe plus data) into the 32-entry register file.
- Supplies registered rs1/rs2 operands to execute.
- Execute carries no destination index, so this block keeps an in-order FIFO of destination indices claimed at issue, plus a busy scoreboard. The scoreboard drives a hazard line to the stall unit.

Parameters:
DW, 32, register/data width
NREGS, 32, architectural register count (index 0 hardwired zero)
RIDX_W, 5, register index width, equals $clog2(NREGS)
DEPTH, 4, in-flight destination FIFO depth (power of two)

Ports:
i_clk  in  1  core clock
i_rst  in  1  reset, synchronous, active-high
i_clk_en  in  1  global clock enable; when low, all state holds
i_stall  in  1  stall unit line; freezes operand registers
i_rs1_idx  in  RIDX_W  source 1 index from decode
i_rs2_idx  in  RIDX_W  source 2 index from decode
i_rd_idx  in  RIDX_W  destination index of instruction being issued
i_issue  in  1  decode issues an instruction that will produce exactly one execute rd write
o_rs1  out  DW  registered operand 1 to execute
o_rs2  out  DW  registered operand 2 to execute
o_hazard  out  1  combinational: issue must not proceed this cycle
i_rd_write  in  1  execute result valid (execute o_rd_write)
i_rd  in  DW  execute result data (execute o_rd)
o_empty  out  1  no results in flight
o_underflow  out  1  sticky error: result arrived with FIFO empty

Behaviour:
- Reset (i_rst high at posedge, takes priority over i_clk_en):
  - all registers and o_rs1/o_rs2 cleared to 0
  - busy bits 0; FIFO empty; o_empty=1; o_underflow=0
  - reset mid-operation discards all in-flight destinations
- i_clk_en low: no state changes. o_hazard and o_empty still track current state combinationally.
- o_hazard:
  - equals busy[i_rs1_idx] | busy[i_rs2_idx] | (i_issue & busy[i_rd_idx]) | fifo_full
  - busy[0] is always 0
  - computed from registered busy only; a busy bit cleared this cycle still stalls this cycle (conservative; no scoreboard bypass)
- Issue, accepted when i_clk_en & i_issue & !o_hazard:
  - push i_rd_idx into the FIFO
  - set busy[i_rd_idx] if i_rd_idx != 0
  - rd = 0 is still pushed so result ordering stays aligned
  - i_issue while o_hazard is high is ignored; decode holds and retries
- Writeback, on i_clk_en & i_rd_write with FIFO non-empty:
  - pop head index h
  - if h != 0: regs[h] <= i_rd and busy[h] <= 0
  - i_stall does not gate writeback; execute already qualifies its own strobe
- Writeback with FIFO empty: no register write; o_underflow <= 1 and stays set until reset.
- Simultaneous push and pop: FIFO count unchanged; pointers both advance and wrap modulo DEPTH.
  - Push and pop can never name the same nonzero register: the WAW term in o_hazard blocks issue of a busy rd.
- Operand read, on i_clk_en & !i_stall:
  - o_rsN <= 0 if idx == 0
  - else <= i_rd if a writeback to that same index commits this cycle (write-first bypass)
  - else <= regs[idx]
  - latency is one cycle; when stalled, o_rs1/o_rs2 hold
- Full condition: count == DEPTH asserts o_hazard regardless of indices. Empty condition: count == 0 asserts o_empty.
- At most one pending write per register; the busy bit clears exactly on its writeback.

Decomposition:
- Shared package core_pkg:
  - typedef RegIdx (logic [4:0])
  - constant REG_ZERO = 0
  - constant WB_FIFO_DEPTH = 4
  - the existing Opcode enum stays there
- Sub-module dest_fifo: synchronous FIFO of RegIdx with push/pop/full/empty, parameterised by DEPTH. It is instantiated once; the register array, scoreboard and bypass remain in the top.

Test Plan:
- Reset, then read x0 and x5 -> o_rs1 = 0 and o_rs2 = 0 one cycle later; o_empty = 1; o_hazard = 0.
- Issue rd = 5; one cycle later i_rd_write with i_rd = 0xDEADBEEF -> busy[5] set in between, so o_hazard = 1 while i_rs1_idx = 5. After writeback o_hazard = 0, and a read of x5 returns 0xDEADBEEF.
- Issue rd = 3, rd = 4, rd = 0, rd = 7 -> fourth issue fills the FIFO and o_hazard = 1 for any index.
  - Results 1, 2, 3, 4 then land x3 = 1, x4 = 2, x7 = 4; x0 reads 0.
  - o_empty = 1 at the end.
- Writeback to x9 = 0x55 in the same cycle that i_rs2_idx = 9 is sampled -> o_rs2 = 0x55 next cycle (bypass).
  - Repeat with i_stall high -> o_rs2 holds its previous value.
- i_rd_write with the FIFO empty -> no register changes; o_underflow = 1 and stays set until i_rst.
- Two issues in flight, then i_rst -> busy cleared, o_empty = 1, o_rs1 = 0.
  - Also toggle i_clk_en low mid-sequence -> no state changes while it is low.
